// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises the nickel/dime sensors, debounces them,
// emits one coin code per insertion, rejects dual-sensor insertions and flags jams.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       enable,
  input  logic       clear_counts,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic [7:0] nickel_count,
  output logic [7:0] dime_count
);

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    EMIT,
    WAIT_RELEASE,
    JAM
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] JAM_LAST = 8'(JAM_CYCLES - 1);

  state_t     state_q, state_d;
  logic       n_meta_q, n_meta_d, n_s_q, n_s_d;
  logic       d_meta_q, d_meta_d, d_s_q, d_s_d;
  logic       n_hist_q, n_hist_d, d_hist_q, d_hist_d;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic [7:0] jam_cnt_q, jam_cnt_d;
  logic       sel_q, sel_d;
  logic [1:0] coin_q, coin_d;
  logic       reject_q, reject_d;
  logic       jam_q, jam_d;
  logic [7:0] nickel_count_q, nickel_count_d;
  logic [7:0] dime_count_q, dime_count_d;

  logic n_rise, d_rise, lat_s, oth_s, any_s;

  // History is held at 1 until the reset-cleared synchronisers carry real
  // sensor data, so a sensor high across reset release never looks like an edge.
  always_comb begin
    n_meta_d   = nickel_in;
    n_s_d      = n_meta_q;
    d_meta_d   = dime_in;
    d_s_d      = d_meta_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    n_hist_d   = sync_vld_q[1] ? n_s_q : 1'b1;
    d_hist_d   = sync_vld_q[1] ? d_s_q : 1'b1;
  end

  assign n_rise = n_s_q & ~n_hist_q;
  assign d_rise = d_s_q & ~d_hist_q;
  assign lat_s  = sel_q ? d_s_q : n_s_q;
  assign oth_s  = sel_q ? n_s_q : d_s_q;
  assign any_s  = n_s_q | d_s_q;

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    jam_cnt_d = jam_cnt_q;
    sel_d     = sel_q;
    coin_d    = '0;
    reject_d  = 1'b0;
    jam_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (n_s_q && d_s_q && (n_rise || d_rise)) begin
            reject_d  = 1'b1;
            jam_cnt_d = '0;
            state_d   = WAIT_RELEASE;
          end else if (n_rise || d_rise) begin
            sel_d     = d_rise;
            deb_cnt_d = 8'd1;
            if (DEBOUNCE_CYCLES == 1) begin
              coin_d  = d_rise ? 2'b10 : 2'b01;
              state_d = EMIT;
            end else begin
              state_d = QUALIFY;
            end
          end
        end
      end
      QUALIFY: begin
        if (oth_s) begin
          reject_d  = 1'b1;
          jam_cnt_d = '0;
          state_d   = WAIT_RELEASE;
        end else if (!lat_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q >= DEB_LAST) begin
          coin_d  = sel_q ? 2'b10 : 2'b01;
          state_d = EMIT;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      EMIT: begin
        jam_cnt_d = '0;
        state_d   = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!any_s) begin
          state_d = IDLE;
        end else if (jam_cnt_q >= JAM_LAST) begin
          jam_d   = 1'b1;
          state_d = JAM;
        end else begin
          jam_cnt_d = jam_cnt_q + 8'd1;
        end
      end
      JAM: begin
        if (!any_s) state_d = IDLE;
        else        jam_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters bump on the cycle the coin code is registered; clear has priority.
  always_comb begin
    nickel_count_d = nickel_count_q;
    dime_count_d   = dime_count_q;
    if (clear_counts) begin
      nickel_count_d = '0;
      dime_count_d   = '0;
    end else begin
      if (coin_d == 2'b01 && nickel_count_q != '1) nickel_count_d = nickel_count_q + 8'd1;
      if (coin_d == 2'b10 && dime_count_q != '1)   dime_count_d   = dime_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      n_meta_q       <= 1'b0;
      n_s_q          <= 1'b0;
      d_meta_q       <= 1'b0;
      d_s_q          <= 1'b0;
      n_hist_q       <= 1'b1;
      d_hist_q       <= 1'b1;
      sync_vld_q     <= '0;
      deb_cnt_q      <= '0;
      jam_cnt_q      <= '0;
      sel_q          <= 1'b0;
      coin_q         <= '0;
      reject_q       <= 1'b0;
      jam_q          <= 1'b0;
      nickel_count_q <= '0;
      dime_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      n_meta_q       <= n_meta_d;
      n_s_q          <= n_s_d;
      d_meta_q       <= d_meta_d;
      d_s_q          <= d_s_d;
      n_hist_q       <= n_hist_d;
      d_hist_q       <= d_hist_d;
      sync_vld_q     <= sync_vld_d;
      deb_cnt_q      <= deb_cnt_d;
      jam_cnt_q      <= jam_cnt_d;
      sel_q          <= sel_d;
      coin_q         <= coin_d;
      reject_q       <= reject_d;
      jam_q          <= jam_d;
      nickel_count_q <= nickel_count_d;
      dime_count_q   <= dime_count_d;
    end
  end

  assign coin         = coin_q;
  assign reject       = reject_q;
  assign jam          = jam_q;
  assign nickel_count = nickel_count_q;
  assign dime_count   = dime_count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed scoreboard bench for coin_acceptor: expected coin/reject events are
// queued with their due cycle when stimulus is driven and matched as they appear.
module tb_coin_acceptor;

  localparam int unsigned DEB = 4;
  localparam int unsigned JAMC = 64;

  logic       clk = 1'b0;
  logic       reset, nickel_in, dime_in, enable, clear_counts;
  logic [1:0] coin;
  logic       reject, jam;
  logic [7:0] nickel_count, dime_count;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .JAM_CYCLES(JAMC)) dut (
    .clk(clk), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
    .enable(enable), .clear_counts(clear_counts), .coin(coin), .reject(reject),
    .jam(jam), .nickel_count(nickel_count), .dime_count(dime_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  coin;
    logic        reject;
    int unsigned cyc;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned exp_nickel = 0;
  int unsigned exp_dime = 0;
  int unsigned c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic r, input int unsigned at);
    ev_t e;
    e.coin = c; e.reject = r; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Advance n clocks; any coin/reject seen must match the head of the queue.
  task automatic run(input int unsigned n);
    ev_t e;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (coin !== 2'b00 || reject !== 1'b0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_event: observed coin=%b reject=%b at cycle %0d, expected none",
                 coin, reject, cyc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("event_coin", 32'(coin), 32'(e.coin));
          chk("event_reject", 32'(reject), 32'(e.reject));
          chk("event_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic all_seen(input string tag);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic nickel_pulse();
    push(2'b01, 1'b0, cyc + DEB + 2);
    nickel_in = 1'b1;
    run(6);
    nickel_in = 1'b0;
    run(4);
    exp_nickel = (exp_nickel == 255) ? 255 : exp_nickel + 1;
  endtask

  initial begin
    reset = 1'b1; nickel_in = 1'b0; dime_in = 1'b0; enable = 1'b1; clear_counts = 1'b0;
    run(3);
    chk("rst_coin", 32'(coin), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_jam", 32'(jam), 0);
    chk("rst_nickel_count", 32'(nickel_count), 0);
    chk("rst_dime_count", 32'(dime_count), 0);
    reset = 1'b0;
    run(4);

    // Nickel accepted with DEB+2 latency
    push(2'b01, 1'b0, cyc + DEB + 2);
    nickel_in = 1'b1; run(10);
    nickel_in = 1'b0; run(6);
    all_seen("nickel_done");
    exp_nickel = 1;
    chk("nickel_count_1", 32'(nickel_count), exp_nickel);

    // Short dime is a glitch
    dime_in = 1'b1; run(2);
    dime_in = 1'b0; run(8);
    all_seen("glitch_done");
    chk("glitch_dime_count", 32'(dime_count), exp_dime);

    // Dime arrives while nickel qualifies
    push(2'b00, 1'b1, cyc + 4);
    nickel_in = 1'b1; run(1);
    dime_in = 1'b1; run(12);
    nickel_in = 1'b0; dime_in = 1'b0; run(6);
    all_seen("qual_reject_done");
    chk("qual_reject_nickel", 32'(nickel_count), exp_nickel);
    chk("qual_reject_dime", 32'(dime_count), exp_dime);

    // Both sensors rise together
    push(2'b00, 1'b1, cyc + 3);
    nickel_in = 1'b1; dime_in = 1'b1; run(8);
    nickel_in = 1'b0; dime_in = 1'b0; run(6);
    all_seen("idle_reject_done");

    // Sensor already high when enable rises is ignored
    enable = 1'b0; nickel_in = 1'b1; run(6);
    enable = 1'b1; run(10);
    nickel_in = 1'b0; run(6);
    all_seen("enable_done");
    chk("enable_nickel_count", 32'(nickel_count), exp_nickel);

    // Held dime: one coin, then jam after JAMC cycles in WAIT_RELEASE
    c0 = cyc;
    push(2'b10, 1'b0, c0 + DEB + 2);
    dime_in = 1'b1;
    run(70);
    chk("jam_early", 32'(jam), 0);
    run(1);
    chk("jam_assert", 32'(jam), 1);
    run(29);
    chk("jam_hold", 32'(jam), 1);
    dime_in = 1'b0;
    run(2);
    chk("jam_before_release", 32'(jam), 1);
    run(1);
    chk("jam_release", 32'(jam), 0);
    run(4);
    all_seen("jam_done");
    exp_dime = 1;
    chk("jam_dime_count", 32'(dime_count), exp_dime);

    // Reset mid-QUALIFY with nickel held: nothing until it re-rises
    nickel_in = 1'b1; run(4);
    reset = 1'b1; run(1);
    reset = 1'b0;
    exp_nickel = 0; exp_dime = 0;
    run(20);
    all_seen("reset_no_coin");
    chk("reset_nickel_count", 32'(nickel_count), exp_nickel);
    chk("reset_dime_count", 32'(dime_count), exp_dime);
    nickel_in = 1'b0; run(5);
    nickel_pulse();
    all_seen("reset_recoin_done");
    chk("reset_recoin_count", 32'(nickel_count), exp_nickel);

    // Saturation at 255
    while (exp_nickel < 255) nickel_pulse();
    all_seen("sat_fill_done");
    chk("sat_reach", 32'(nickel_count), 255);
    nickel_pulse();
    all_seen("sat_extra_done");
    chk("sat_hold", 32'(nickel_count), exp_nickel);

    // Clear coincident with dime emit
    c0 = cyc;
    push(2'b10, 1'b0, c0 + DEB + 2);
    dime_in = 1'b1; run(5);
    clear_counts = 1'b1; run(1);
    clear_counts = 1'b0;
    exp_nickel = 0; exp_dime = 0;
    chk("clear_nickel", 32'(nickel_count), exp_nickel);
    chk("clear_dime", 32'(dime_count), exp_dime);
    run(1);
    chk("clear_dime_after", 32'(dime_count), exp_dime);
    dime_in = 1'b0; run(6);
    all_seen("clear_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive synchronized-high cycles needed to accept a coin (legal range 1..255).
REQ-002 Parameter JAM_CYCLES, default 64, is the number of cycles a sensor may stay high after acceptance before jam is flagged (legal range 1..255).
REQ-003 Port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port nickel_in, input, 1 bit: raw, asynchronous 5-unit coin sensor, high while a coin passes.
REQ-006 Port dime_in, input, 1 bit: raw, asynchronous 10-unit coin sensor, high while a coin passes.
REQ-007 Port enable, input, 1 bit: when low, no new coin is qualified.
REQ-008 Port clear_counts, input, 1 bit: synchronous clear of both coin counters.
REQ-009 Port coin, output, 2 bits: 2'b01 = nickel, 2'b10 = dime, 2'b00 = none; feeds the downstream vending FSM coin input.
REQ-010 Port reject, output, 1 bit: one-cycle pulse on an invalid (dual-sensor) insertion.
REQ-011 Port jam, output, 1 bit: high while in JAM state.
REQ-012 Port nickel_count, output, 8 bits: accepted nickels, saturating.
REQ-013 Port dime_count, output, 8 bits: accepted dimes, saturating.

Function
REQ-014 Each raw sensor SHALL pass through a 2-flop synchronizer; only synchronized values (n_s, d_s) are used internally.
REQ-015 Each synchronized sensor SHALL have a history flop for rising-edge detection; an edge is sync=1 while history=0.
REQ-016 coin, reject and jam SHALL be registered outputs; coin is 2'b11 in no cycle.
REQ-017 The FSM SHALL have states IDLE, QUALIFY, EMIT, WAIT_RELEASE, JAM.
REQ-018 IDLE: if enable=1 and exactly one sensor has a rising edge, latch that sensor, load debounce counter, go to QUALIFY.
REQ-019 IDLE: if enable=1 and both sensors high with at least one rising edge, pulse reject for one cycle and go to WAIT_RELEASE.
REQ-020 IDLE: if enable=0, edges are ignored and the FSM stays in IDLE; a sensor already high when enable rises is not accepted.
REQ-021 QUALIFY: latched sensor high and other sensor low extends the debounce count; reaching DEBOUNCE_CYCLES consecutive high cycles, counting the edge cycle, goes to EMIT.
REQ-022 QUALIFY: latched sensor low before the count completes is a glitch; return to IDLE with no coin and no reject.
REQ-023 QUALIFY: other sensor high pulses reject for one cycle and goes to WAIT_RELEASE; no coin is emitted.
REQ-024 QUALIFY ignores enable going low once entered.
REQ-025 EMIT: coin SHALL equal the latched code for exactly one cycle, then go to WAIT_RELEASE.
REQ-026 End-to-end latency SHALL be DEBOUNCE_CYCLES+2 clock edges, from the first edge sampling a raw sensor high to coin asserted (6 at default).
REQ-027 With each EMIT, the matching counter SHALL increment by 1, saturating at 255.
REQ-028 clear_counts=1 SHALL zero both counters next cycle and wins over a coincident increment; the coin output is unaffected.
REQ-029 WAIT_RELEASE: when n_s=0 and d_s=0, go to IDLE; a cycle counter runs, and JAM_CYCLES cycles with either sensor high go to JAM.
REQ-030 JAM: jam=1; no coins or rejects; when n_s=0 and d_s=0, go to IDLE and deassert jam next cycle.
REQ-031 At most one coin or reject event SHALL occur per sensor assertion.

Reset
REQ-032 reset=1 SHALL asynchronously force: state IDLE; coin=2'b00, reject=0, jam=0, both counts=0; synchronizers=0; debounce/jam counters=0.
REQ-033 History flops SHALL reset to 1, so a sensor held high across reset release is not accepted until it falls and rises again.
REQ-034 Reset mid-QUALIFY or mid-EMIT SHALL discard the coin in progress with no coin pulse and no count change.

Verification
REQ-035 nickel_in high 10 cycles, enable=1 -> coin=01 for one cycle 6 edges after first sample; nickel_count=1.
REQ-036 dime_in high 2 cycles -> glitch; coin stays 00, reject=0, dime_count=0.
REQ-037 nickel_in then dime_in rising 1 cycle later, both held -> reject one-cycle pulse, no coin, counts unchanged.
REQ-038 dime_in held 100 cycles -> one coin=10, jam=1 after 64 cycles in WAIT_RELEASE; release -> jam=0, IDLE.
REQ-039 Preload nickel_count to 255 via 255 coins, insert one more -> count stays 255; clear_counts coincident with a dime EMIT -> both counts 0, coin=10 still emitted.
REQ-040 reset pulsed during QUALIFY with nickel_in held high through release -> no coin until nickel_in falls and rises again.
